sram_like_arbiter: RTL and testbench
====================================

Name: sram_like_arbiter

Overview:
- Parametrised N-channel SRAM-like request arbiter between the pipeline memory ports (fetch, load/store, future cache refill/writeback) and one shared SRAM-like downstream port.
- Successor to the fixed separate inst/data SRAM split: generalised in channel count, data width and outstanding depth.
- Supports fixed-priority or round-robin arbitration.
- An in-order tag FIFO routes each response back to its requesting channel.

Parameters:
- NUM_CH, 2, number of upstream channels (2..8); channel 0 is instruction fetch by convention.
- DATA_W, 32, data bus width (32 or 64).
- ADDR_W, 32, address width.
- OUT_DEPTH, 4, max outstanding accepted-but-unanswered requests (power of two, 2..16).
- RR_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- ch_req  in  NUM_CH  per-channel request valid.
- ch_wr  in  NUM_CH  per-channel write flag.
- ch_size  in  2*NUM_CH  per-channel access size (0 = byte, 1 = half, 2 = word, 3 = dword).
- ch_addr  in  ADDR_W*NUM_CH  per-channel address.
- ch_wstrb  in  (DATA_W/8)*NUM_CH  per-channel byte strobes.
- ch_wdata  in  DATA_W*NUM_CH  per-channel write data.
- ch_addr_ok  out  NUM_CH  request accepted (one-hot or zero).
- ch_data_ok  out  NUM_CH  response returned (one-hot or zero).
- ch_rdata  out  DATA_W  read data, broadcast to all channels.
- mem_req  out  1  downstream request valid.
- mem_wr  out  1  downstream write flag.
- mem_size  out  2  downstream access size.
- mem_addr  out  ADDR_W  downstream address.
- mem_wstrb  out  DATA_W/8  downstream byte strobes.
- mem_wdata  out  DATA_W  downstream write data.
- mem_addr_ok  in  1  downstream accepted the request.
- mem_data_ok  in  1  downstream response valid (in order).
- mem_rdata  in  DATA_W  downstream read data.
- outstanding  out  clog2(OUT_DEPTH)+1  current tag FIFO occupancy.
- proto_err  out  1  sticky: mem_data_ok seen with the FIFO empty.

Behaviour:
- Reset (async, resetn low): FIFO count = 0, rd/wr pointers = 0, rr_ptr = 0, lock = 0, proto_err = 0.
  - mem_req, ch_addr_ok and ch_data_ok are 0 during and after reset.
  - ch_rdata and mem_* data fields are don't-care.
- Eligibility: ch_req[i] & ~fifo_full.
- mem_req = any eligible channel. When the FIFO is full, mem_req = 0 and all ch_addr_ok = 0.
- Selection:
  - RR_MODE = 0: lowest-index eligible channel.
  - RR_MODE = 1: first eligible channel at or after rr_ptr, wrapping modulo NUM_CH.
- Grant lock:
  - If mem_req = 1 and mem_addr_ok = 0, register lock = 1 and hold the granted index.
  - While locked, the grant ignores higher-priority arrivals.
  - Lock clears on acceptance.
  - The upstream master holds req and fields stable until addr_ok (protocol rule).
- mem_wr / size / addr / wstrb / wdata are muxed combinationally from the granted channel; zero-cycle request latency.
- Acceptance:
  - Condition: mem_req & mem_addr_ok.
  - ch_addr_ok[g] = 1 for that cycle only.
  - Push {g, wr} into the tag FIFO.
  - RR_MODE = 1: rr_ptr <= (g + 1) mod NUM_CH.
- Response:
  - Condition: mem_data_ok & ~fifo_empty.
  - ch_data_ok[head.id] = 1 combinationally; ch_rdata = mem_rdata; pop head.
  - Write responses also pop and pulse data_ok; rdata is don't-care.
- Simultaneous push and pop in the same cycle: count unchanged, both pointers advance.
- No full-bypass: a push is never permitted when count == OUT_DEPTH, even if a pop occurs that cycle (acceptance gated at the registered full).
- Error case: mem_data_ok with FIFO empty → ignored (no ch_data_ok, pointers unchanged); proto_err set, sticky until reset.
- Pointer wrap: rd/wr pointers wrap modulo OUT_DEPTH; count saturates at OUT_DEPTH by construction.
- Reset mid-transaction: all outstanding tags are discarded. The system resets downstream simultaneously; late responses after reset flag proto_err.

Decomposition:
- Package my_cpu.vh additions:
  - size encoding constants (SZ_B, SZ_H, SZ_W, SZ_D);
  - tag width define = clog2(NUM_CH) + 1;
  - default OUT_DEPTH.
- Sub-module arb_tag_fifo:
  - synchronous FIFO with parametrised width/depth, async active-low reset;
  - push/pop/full/empty/count ports;
  - instantiated once.
- Arbiter logic and muxing stay in the top.

Test Plan:
- NUM_CH=2, RR_MODE=0: both channels request on the same cycle, mem_addr_ok=1 → ch_addr_ok=2'b01 first, then 2'b10 next cycle; responses return 0xAAAA0000 to ch0 then 0xBBBB0000 to ch1 via ch_data_ok=01 then 10.
- RR_MODE=1, NUM_CH=4, all four request continuously with mem_addr_ok=1 → grant order 0,1,2,3,0; rr_ptr wraps.
- Lock: ch1 requests, mem_addr_ok=0 for 3 cycles, ch0 raises req in cycle 2 → mem_addr stays ch1's 0x1C000100 until accepted; ch0 is granted after.
- OUT_DEPTH=4: 4 accepts with no data_ok → outstanding=4, mem_req=0. One mem_data_ok → outstanding=3 and the next request is accepted the following cycle, not the same cycle.
- Simultaneous push/pop at outstanding=2 → outstanding stays 2; the popped tag routes to the correct channel.
- mem_data_ok pulse with outstanding=0 → no ch_data_ok; proto_err=1 and held. resetn low asynchronously → proto_err=0 and mem_req=0 immediately.

Source files
------------

// File: rtl/sram_like_arbiter_pkg.sv
// ============================================================================
// sram_like_arbiter_pkg: shared constants and helpers for the SRAM-like arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package sram_like_arbiter_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam int DEF_OUT_DEPTH = 4;

    // Tag carries the channel index plus the write flag of the request.
    function automatic int tag_w(input int num_ch);
        return $clog2(num_ch) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sram_like_arbiter_tag_fifo.sv
// ============================================================================
// sram_like_arbiter_tag_fifo: in-order tag FIFO, power-of-two depth
// Rev 1.0
// ============================================================================
`default_nettype none

module sram_like_arbiter_tag_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam logic [c_ptr_w:0] c_full = (c_ptr_w + 1)'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_push;
    logic               w_pop;

    assign full     = (r_count == c_full);
    assign empty    = (r_count == '0);
    assign count    = r_count;
    assign pop_data = r_mem[r_rd_ptr];
    assign w_push   = push & ~full;
    assign w_pop    = pop & ~empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_ptr_w + 1)'(1);
                2'b01:   r_count <= r_count - (c_ptr_w + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/sram_like_arbiter.sv
// ============================================================================
// sram_like_arbiter: N-channel SRAM-like request arbiter onto one memory port
// Rev 1.0
// ============================================================================
`default_nettype none

module sram_like_arbiter
    import sram_like_arbiter_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int OUT_DEPTH = DEF_OUT_DEPTH,
    parameter int RR_MODE   = 1
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [NUM_CH-1:0]            ch_req,
    input  logic [NUM_CH-1:0]            ch_wr,
    input  logic [2*NUM_CH-1:0]          ch_size,
    input  logic [ADDR_W*NUM_CH-1:0]     ch_addr,
    input  logic [(DATA_W/8)*NUM_CH-1:0] ch_wstrb,
    input  logic [DATA_W*NUM_CH-1:0]     ch_wdata,
    output logic [NUM_CH-1:0]            ch_addr_ok,
    output logic [NUM_CH-1:0]            ch_data_ok,
    output logic [DATA_W-1:0]            ch_rdata,
    output logic                         mem_req,
    output logic                         mem_wr,
    output logic [1:0]                   mem_size,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W/8-1:0]          mem_wstrb,
    output logic [DATA_W-1:0]            mem_wdata,
    input  logic                         mem_addr_ok,
    input  logic                         mem_data_ok,
    input  logic [DATA_W-1:0]            mem_rdata,
    output logic [$clog2(OUT_DEPTH):0]   outstanding,
    output logic                         proto_err
);

    localparam int c_id_w   = $clog2(NUM_CH);
    localparam int c_tag_w  = tag_w(NUM_CH);
    localparam int c_strb_w = DATA_W / 8;

    logic                r_lock;
    logic [c_id_w-1:0]   r_lock_idx;
    logic [c_id_w-1:0]   r_rr_ptr;
    logic                w_full;
    logic                w_empty;
    logic [c_tag_w-1:0]  w_head;
    logic [c_id_w-1:0]   w_head_id;
    logic                w_head_wr;
    logic [NUM_CH-1:0]   w_elig;
    logic [c_id_w-1:0]   w_base;
    logic [c_id_w:0]     w_idx;
    logic [c_id_w-1:0]   w_cand;
    logic [c_id_w-1:0]   w_sel;
    logic [c_id_w-1:0]   w_grant;
    logic                w_accept;
    logic                w_pop;

    assign w_elig  = ch_req & {NUM_CH{~w_full}};
    assign mem_req = resetn & (|w_elig);
    assign w_base  = (RR_MODE != 0) ? r_rr_ptr : '0;

    // Scan from the highest offset down so the lowest offset from w_base wins.
    always_comb begin
        w_sel  = '0;
        w_idx  = '0;
        w_cand = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            w_idx = {1'b0, w_base} + (c_id_w + 1)'(k);
            if (w_idx >= (c_id_w + 1)'(NUM_CH)) begin
                w_idx = w_idx - (c_id_w + 1)'(NUM_CH);
            end
            w_cand = w_idx[c_id_w-1:0];
            if (w_elig[w_cand]) begin
                w_sel = w_cand;
            end
        end
    end

    assign w_grant    = r_lock ? r_lock_idx : w_sel;
    assign w_accept   = mem_req & mem_addr_ok;
    assign ch_addr_ok = w_accept ? (NUM_CH'(1) << w_grant) : '0;

    always_comb begin
        mem_wr    = 1'b0;
        mem_size  = '0;
        mem_addr  = '0;
        mem_wstrb = '0;
        mem_wdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_grant == c_id_w'(i)) begin
                mem_wr    = ch_wr[i];
                mem_size  = ch_size[i*2 +: 2];
                mem_addr  = ch_addr[i*ADDR_W +: ADDR_W];
                mem_wstrb = ch_wstrb[i*c_strb_w +: c_strb_w];
                mem_wdata = ch_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_pop      = mem_data_ok & ~w_empty;
    assign w_head_id  = w_head[c_tag_w-1:1];
    assign w_head_wr  = w_head[0];
    assign ch_data_ok = w_pop ? (NUM_CH'(1) << w_head_id) : '0;
    // Write responses carry no data; return zero rather than bus noise.
    assign ch_rdata   = w_head_wr ? '0 : mem_rdata;

    sram_like_arbiter_tag_fifo #(
        .WIDTH (c_tag_w),
        .DEPTH (OUT_DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (w_accept),
        .push_data ({w_grant, mem_wr}),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (outstanding)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
            r_rr_ptr   <= '0;
            proto_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_lock <= 1'b0;
            end else if (mem_req) begin
                r_lock     <= 1'b1;
                r_lock_idx <= w_grant;
            end
            if (w_accept && (RR_MODE != 0)) begin
                r_rr_ptr <= (w_grant == c_id_w'(NUM_CH - 1)) ? '0 : w_grant + c_id_w'(1);
            end
            if (mem_data_ok && w_empty) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sram_like_arbiter.sv
// ============================================================================
// tb_sram_like_arbiter: directed bench, fixed-priority (A) and round-robin (B)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sram_like_arbiter;

    logic clk = 1'b0;
    logic resetn;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    logic [1:0]  a_req, a_wr, a_aok, a_dok;
    logic [3:0]  a_size;
    logic [63:0] a_addr, a_wdata;
    logic [7:0]  a_wstrb;
    logic [31:0] a_rdata, a_maddr, a_mwdata, a_mrdata;
    logic        a_mreq, a_mwr, a_maok, a_mdok, a_perr;
    logic [1:0]  a_msize;
    logic [3:0]  a_mwstrb;
    logic [2:0]  a_out;

    logic [3:0]   b_req, b_wr, b_aok, b_dok;
    logic [7:0]   b_size;
    logic [127:0] b_addr, b_wdata;
    logic [15:0]  b_wstrb;
    logic [31:0]  b_rdata, b_maddr, b_mwdata, b_mrdata;
    logic         b_mreq, b_mwr, b_maok, b_mdok, b_perr;
    logic [1:0]   b_msize;
    logic [3:0]   b_mwstrb;
    logic [3:0]   b_out;

    sram_like_arbiter #(
        .NUM_CH(2), .DATA_W(32), .ADDR_W(32), .OUT_DEPTH(4), .RR_MODE(0)
    ) dut_a (
        .clk(clk), .resetn(resetn),
        .ch_req(a_req), .ch_wr(a_wr), .ch_size(a_size), .ch_addr(a_addr),
        .ch_wstrb(a_wstrb), .ch_wdata(a_wdata),
        .ch_addr_ok(a_aok), .ch_data_ok(a_dok), .ch_rdata(a_rdata),
        .mem_req(a_mreq), .mem_wr(a_mwr), .mem_size(a_msize), .mem_addr(a_maddr),
        .mem_wstrb(a_mwstrb), .mem_wdata(a_mwdata),
        .mem_addr_ok(a_maok), .mem_data_ok(a_mdok), .mem_rdata(a_mrdata),
        .outstanding(a_out), .proto_err(a_perr)
    );

    sram_like_arbiter #(
        .NUM_CH(4), .DATA_W(32), .ADDR_W(32), .OUT_DEPTH(8), .RR_MODE(1)
    ) dut_b (
        .clk(clk), .resetn(resetn),
        .ch_req(b_req), .ch_wr(b_wr), .ch_size(b_size), .ch_addr(b_addr),
        .ch_wstrb(b_wstrb), .ch_wdata(b_wdata),
        .ch_addr_ok(b_aok), .ch_data_ok(b_dok), .ch_rdata(b_rdata),
        .mem_req(b_mreq), .mem_wr(b_mwr), .mem_size(b_msize), .mem_addr(b_maddr),
        .mem_wstrb(b_mwstrb), .mem_wdata(b_mwdata),
        .mem_addr_ok(b_maok), .mem_data_ok(b_mdok), .mem_rdata(b_mrdata),
        .outstanding(b_out), .proto_err(b_perr)
    );

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_all();
        a_req = '0; a_wr = '0; a_size = '0; a_addr = '0; a_wstrb = '0; a_wdata = '0;
        a_maok = 1'b0; a_mdok = 1'b0; a_mrdata = '0;
        b_req = '0; b_wr = '0; b_size = '0; b_addr = '0; b_wstrb = '0; b_wdata = '0;
        b_maok = 1'b0; b_mdok = 1'b0; b_mrdata = '0;
    endtask

    task automatic test_reset();
        idle_all();
        resetn = 1'b0;
        a_req  = 2'b11;
        a_maok = 1'b1;
        b_req  = 4'hF;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (a_mreq !== 1'b0) begin errors++; $display("FAIL rst_a_mreq got %b exp 0", a_mreq); end
        checks++; if (a_aok !== 2'b00) begin errors++; $display("FAIL rst_a_aok got %b exp 00", a_aok); end
        checks++; if (a_dok !== 2'b00) begin errors++; $display("FAIL rst_a_dok got %b exp 00", a_dok); end
        checks++; if (a_out !== 3'd0) begin errors++; $display("FAIL rst_a_out got %0d exp 0", a_out); end
        checks++; if (a_perr !== 1'b0) begin errors++; $display("FAIL rst_a_perr got %b exp 0", a_perr); end
        checks++; if (b_mreq !== 1'b0) begin errors++; $display("FAIL rst_b_mreq got %b exp 0", b_mreq); end
        checks++; if (b_out !== 4'd0) begin errors++; $display("FAIL rst_b_out got %0d exp 0", b_out); end
        @(negedge clk);
        idle_all();
        resetn = 1'b1;
    endtask

    task automatic test_fixed_priority();
        @(negedge clk);
        a_req = 2'b11; a_addr = {32'h0000_0200, 32'h0000_0100}; a_size = 4'b1010; a_maok = 1'b1;
        #1;
        checks++; if (a_mreq !== 1'b1) begin errors++; $display("FAIL fp_mreq got %b exp 1", a_mreq); end
        checks++; if (a_aok !== 2'b01) begin errors++; $display("FAIL fp_aok0 got %b exp 01", a_aok); end
        checks++; if (a_maddr !== 32'h100) begin errors++; $display("FAIL fp_addr0 got %h exp 00000100", a_maddr); end
        checks++; if (a_msize !== 2'd2) begin errors++; $display("FAIL fp_size got %0d exp 2", a_msize); end
        @(negedge clk);
        a_req = 2'b10;
        #1;
        checks++; if (a_aok !== 2'b10) begin errors++; $display("FAIL fp_aok1 got %b exp 10", a_aok); end
        checks++; if (a_maddr !== 32'h200) begin errors++; $display("FAIL fp_addr1 got %h exp 00000200", a_maddr); end
        checks++; if (a_out !== 3'd1) begin errors++; $display("FAIL fp_out1 got %0d exp 1", a_out); end
        @(negedge clk);
        a_req = 2'b00; a_maok = 1'b0; a_mdok = 1'b1; a_mrdata = 32'hAAAA_0000;
        #1;
        checks++; if (a_out !== 3'd2) begin errors++; $display("FAIL fp_out2 got %0d exp 2", a_out); end
        checks++; if (a_dok !== 2'b01) begin errors++; $display("FAIL fp_dok0 got %b exp 01", a_dok); end
        checks++; if (a_rdata !== 32'hAAAA_0000) begin errors++; $display("FAIL fp_rdata0 got %h exp AAAA0000", a_rdata); end
        @(negedge clk);
        a_mrdata = 32'hBBBB_0000;
        #1;
        checks++; if (a_dok !== 2'b10) begin errors++; $display("FAIL fp_dok1 got %b exp 10", a_dok); end
        checks++; if (a_rdata !== 32'hBBBB_0000) begin errors++; $display("FAIL fp_rdata1 got %h exp BBBB0000", a_rdata); end
        @(negedge clk);
        a_mdok = 1'b0;
        #1;
        checks++; if (a_out !== 3'd0) begin errors++; $display("FAIL fp_out_end got %0d exp 0", a_out); end
        checks++; if (a_dok !== 2'b00) begin errors++; $display("FAIL fp_dok_end got %b exp 00", a_dok); end
    endtask

    task automatic test_lock();
        @(negedge clk);
        a_req = 2'b10; a_addr = {32'h1C00_0100, 32'h0000_0040}; a_wr = 2'b10;
        a_wstrb = 8'hF0; a_wdata = {32'h1234_5678, 32'h0}; a_maok = 1'b0;
        #1;
        checks++; if (a_maddr !== 32'h1C00_0100) begin errors++; $display("FAIL lk_addr_c1 got %h exp 1C000100", a_maddr); end
        checks++; if (a_aok !== 2'b00) begin errors++; $display("FAIL lk_aok_c1 got %b exp 00", a_aok); end
        checks++; if (a_mwr !== 1'b1) begin errors++; $display("FAIL lk_wr got %b exp 1", a_mwr); end
        @(negedge clk);
        a_req = 2'b11;
        #1;
        checks++; if (a_maddr !== 32'h1C00_0100) begin errors++; $display("FAIL lk_addr_c2 got %h exp 1C000100", a_maddr); end
        checks++; if (a_mwstrb !== 4'hF) begin errors++; $display("FAIL lk_wstrb got %h exp F", a_mwstrb); end
        checks++; if (a_mwdata !== 32'h1234_5678) begin errors++; $display("FAIL lk_wdata got %h exp 12345678", a_mwdata); end
        @(negedge clk);
        #1;
        checks++; if (a_maddr !== 32'h1C00_0100) begin errors++; $display("FAIL lk_addr_c3 got %h exp 1C000100", a_maddr); end
        checks++; if (a_aok !== 2'b00) begin errors++; $display("FAIL lk_aok_c3 got %b exp 00", a_aok); end
        @(negedge clk);
        a_maok = 1'b1;
        #1;
        checks++; if (a_aok !== 2'b10) begin errors++; $display("FAIL lk_aok_acc got %b exp 10", a_aok); end
        checks++; if (a_maddr !== 32'h1C00_0100) begin errors++; $display("FAIL lk_addr_acc got %h exp 1C000100", a_maddr); end
        @(negedge clk);
        a_req = 2'b01;
        #1;
        checks++; if (a_aok !== 2'b01) begin errors++; $display("FAIL lk_aok_ch0 got %b exp 01", a_aok); end
        checks++; if (a_maddr !== 32'h40) begin errors++; $display("FAIL lk_addr_ch0 got %h exp 00000040", a_maddr); end
        checks++; if (a_mwr !== 1'b0) begin errors++; $display("FAIL lk_wr_ch0 got %b exp 0", a_mwr); end
        @(negedge clk);
        a_req = 2'b00; a_maok = 1'b0; a_mdok = 1'b1; a_mrdata = 32'h0;
        #1;
        checks++; if (a_dok !== 2'b10) begin errors++; $display("FAIL lk_dok_wr got %b exp 10", a_dok); end
        checks++; if (a_out !== 3'd2) begin errors++; $display("FAIL lk_out got %0d exp 2", a_out); end
        @(negedge clk);
        a_mrdata = 32'h5555_AAAA;
        #1;
        checks++; if (a_dok !== 2'b01) begin errors++; $display("FAIL lk_dok_rd got %b exp 01", a_dok); end
        checks++; if (a_rdata !== 32'h5555_AAAA) begin errors++; $display("FAIL lk_rdata got %h exp 5555AAAA", a_rdata); end
        @(negedge clk);
        a_mdok = 1'b0; a_wr = 2'b00;
        #1;
        checks++; if (a_out !== 3'd0) begin errors++; $display("FAIL lk_out_end got %0d exp 0", a_out); end
    endtask

    task automatic test_full();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) begin
                a_req = 2'b01; a_addr = {32'h0, 32'h0000_0300}; a_maok = 1'b1;
            end
            #1;
            checks++; if (a_aok !== 2'b01) begin errors++; $display("FAIL full_aok_%0d got %b exp 01", k, a_aok); end
            checks++; if (a_out !== 3'(k)) begin errors++; $display("FAIL full_out_%0d got %0d exp %0d", k, a_out, k); end
        end
        @(negedge clk);
        #1;
        checks++; if (a_out !== 3'd4) begin errors++; $display("FAIL full_out4 got %0d exp 4", a_out); end
        checks++; if (a_mreq !== 1'b0) begin errors++; $display("FAIL full_mreq got %b exp 0", a_mreq); end
        checks++; if (a_aok !== 2'b00) begin errors++; $display("FAIL full_aok got %b exp 00", a_aok); end
        @(negedge clk);
        a_mdok = 1'b1; a_mrdata = 32'h1111_0000;
        #1;
        checks++; if (a_dok !== 2'b01) begin errors++; $display("FAIL full_pop_dok got %b exp 01", a_dok); end
        checks++; if (a_aok !== 2'b00) begin errors++; $display("FAIL full_nobypass got %b exp 00", a_aok); end
        @(negedge clk);
        a_mdok = 1'b0;
        #1;
        checks++; if (a_out !== 3'd3) begin errors++; $display("FAIL full_out3 got %0d exp 3", a_out); end
        checks++; if (a_aok !== 2'b01) begin errors++; $display("FAIL full_reaccept got %b exp 01", a_aok); end
        @(negedge clk);
        a_req = 2'b00; a_maok = 1'b0;
        #1;
        checks++; if (a_out !== 3'd4) begin errors++; $display("FAIL full_out4b got %0d exp 4", a_out); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            a_mdok = 1'b1;
            #1;
            checks++; if (a_dok !== 2'b01) begin errors++; $display("FAIL full_drain_%0d got %b exp 01", k, a_dok); end
        end
        @(negedge clk);
        a_mdok = 1'b0;
        #1;
        checks++; if (a_out !== 3'd0) begin errors++; $display("FAIL full_out_end got %0d exp 0", a_out); end
    endtask

    task automatic test_push_pop();
        @(negedge clk);
        a_req = 2'b10; a_maok = 1'b1;
        #1;
        checks++; if (a_aok !== 2'b10) begin errors++; $display("FAIL pp_aok1 got %b exp 10", a_aok); end
        @(negedge clk);
        a_req = 2'b01;
        #1;
        checks++; if (a_aok !== 2'b01) begin errors++; $display("FAIL pp_aok0 got %b exp 01", a_aok); end
        @(negedge clk);
        a_req = 2'b10; a_mdok = 1'b1; a_mrdata = 32'hCAFE_0001;
        #1;
        checks++; if (a_out !== 3'd2) begin errors++; $display("FAIL pp_out_pre got %0d exp 2", a_out); end
        checks++; if (a_aok !== 2'b10) begin errors++; $display("FAIL pp_aok_sim got %b exp 10", a_aok); end
        checks++; if (a_dok !== 2'b10) begin errors++; $display("FAIL pp_dok_sim got %b exp 10", a_dok); end
        checks++; if (a_rdata !== 32'hCAFE_0001) begin errors++; $display("FAIL pp_rdata got %h exp CAFE0001", a_rdata); end
        @(negedge clk);
        a_req = 2'b00; a_maok = 1'b0; a_mrdata = 32'hCAFE_0002;
        #1;
        checks++; if (a_out !== 3'd2) begin errors++; $display("FAIL pp_out_post got %0d exp 2", a_out); end
        checks++; if (a_dok !== 2'b01) begin errors++; $display("FAIL pp_dok_a got %b exp 01", a_dok); end
        @(negedge clk);
        a_mrdata = 32'hCAFE_0003;
        #1;
        checks++; if (a_dok !== 2'b10) begin errors++; $display("FAIL pp_dok_b got %b exp 10", a_dok); end
        @(negedge clk);
        a_mdok = 1'b0;
        #1;
        checks++; if (a_out !== 3'd0) begin errors++; $display("FAIL pp_out_end got %0d exp 0", a_out); end
    endtask

    task automatic test_round_robin();
        int ord [5] = '{0, 1, 2, 3, 0};
        int rsp [7] = '{0, 1, 2, 3, 0, 2, 0};
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) begin
                b_req  = 4'hF;
                b_addr = {32'h0000_1030, 32'h0000_1020, 32'h0000_1010, 32'h0000_1000};
                b_maok = 1'b1;
            end
            #1;
            checks++; if (b_aok !== 4'(1 << ord[k])) begin errors++; $display("FAIL rr_aok_%0d got %b exp ch%0d", k, b_aok, ord[k]); end
            checks++; if (b_maddr !== 32'(32'h1000 + ord[k] * 16)) begin errors++; $display("FAIL rr_addr_%0d got %h exp ch%0d", k, b_maddr, ord[k]); end
        end
        @(negedge clk);
        b_req = 4'b0101;
        #1;
        checks++; if (b_aok !== 4'b0100) begin errors++; $display("FAIL rr_skip got %b exp 0100", b_aok); end
        @(negedge clk);
        b_req = 4'b0001;
        #1;
        checks++; if (b_aok !== 4'b0001) begin errors++; $display("FAIL rr_wrap got %b exp 0001", b_aok); end
        @(negedge clk);
        b_req = 4'b0000; b_maok = 1'b0;
        #1;
        checks++; if (b_out !== 4'd7) begin errors++; $display("FAIL rr_out got %0d exp 7", b_out); end
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            b_mdok = 1'b1;
            #1;
            checks++; if (b_dok !== 4'(1 << rsp[k])) begin errors++; $display("FAIL rr_dok_%0d got %b exp ch%0d", k, b_dok, rsp[k]); end
        end
        @(negedge clk);
        b_mdok = 1'b0;
        #1;
        checks++; if (b_out !== 4'd0) begin errors++; $display("FAIL rr_out_end got %0d exp 0", b_out); end
    endtask

    task automatic test_proto_err();
        @(negedge clk);
        a_mdok = 1'b1;
        #1;
        checks++; if (a_dok !== 2'b00) begin errors++; $display("FAIL pe_dok got %b exp 00", a_dok); end
        @(negedge clk);
        a_mdok = 1'b0;
        #1;
        checks++; if (a_perr !== 1'b1) begin errors++; $display("FAIL pe_set got %b exp 1", a_perr); end
        checks++; if (a_out !== 3'd0) begin errors++; $display("FAIL pe_out got %0d exp 0", a_out); end
        @(negedge clk);
        a_req = 2'b01;
        #1;
        checks++; if (a_perr !== 1'b1) begin errors++; $display("FAIL pe_hold got %b exp 1", a_perr); end
        checks++; if (a_mreq !== 1'b1) begin errors++; $display("FAIL pe_mreq_pre got %b exp 1", a_mreq); end
        #2;
        resetn = 1'b0;
        #1;
        checks++; if (a_perr !== 1'b0) begin errors++; $display("FAIL pe_async_clr got %b exp 0", a_perr); end
        checks++; if (a_mreq !== 1'b0) begin errors++; $display("FAIL pe_async_mreq got %b exp 0", a_mreq); end
        @(negedge clk);
        a_req  = 2'b00;
        resetn = 1'b1;
    endtask

    initial begin
        test_reset();
        test_fixed_priority();
        test_lock();
        test_full();
        test_push_pop();
        test_round_robin();
        test_proto_err();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
